// File: rtl/blit_pkg.sv
// Shared definitions for the blitter RAM arbiter: state encodings, bus widths, parameter defaults.
package blit_pkg;

  localparam int ADDR_W          = 18;
  localparam int DATA_W          = 16;
  localparam int DEF_MAX_VID_RUN = 4;
  localparam int DEF_TIMEOUT     = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_VID  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/blit_req_slot.sv
// One pending-request slot: captures a request pulse, holds it until cleared.
// o_vld/o_* also reflect a same-cycle pulse so an idle arbiter can grant with 1-cycle latency.
module blit_req_slot
  import blit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_wstrb,
  input  logic              i_we,
  input  logic              i_clr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [1:0]        o_wstrb,
  output logic              o_we
);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_wstrb;
  logic              r_we;

  // A pulse while already pending is dropped; the completing clear wins over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= 2'b00;
      r_we    <= 1'b0;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end else if (i_req && !r_pend) begin
      r_pend  <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_wstrb <= i_wstrb;
      r_we    <= i_we;
    end
  end

  assign o_vld   = r_pend | i_req;
  assign o_addr  = r_pend ? r_addr  : i_addr;
  assign o_wdata = r_pend ? r_wdata : i_wdata;
  assign o_wstrb = r_pend ? r_wstrb : i_wstrb;
  assign o_we    = r_pend ? r_we    : i_we;

endmodule

// File: rtl/blit_ram_arb.sv
// CPU/video arbiter for the shared blitter RAM; video wins until MAX_VID_RUN grants starve a waiting CPU.
// Request-to-mem_req latency 1 cycle, one access in flight; BLIT_ARB_TIMEOUT_EN adds an mem_ack watchdog.
module blit_ram_arb
  import blit_pkg::*;
#(
  parameter int MAX_VID_RUN = DEF_MAX_VID_RUN,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ram_req,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [DATA_W-1:0] cpu_ram_wdata,
  input  logic [1:0]        cpu_ram_wstrb,
  input  logic              cpu_ram_we,
  output logic              cpu_ram_ack,
  output logic [DATA_W-1:0] cpu_ram_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wstrb,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int RUN_W = (MAX_VID_RUN < 1) ? 1 : $clog2(MAX_VID_RUN + 1);

  if (MAX_VID_RUN < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("blit_ram_arb: MAX_VID_RUN and TIMEOUT must be at least 1");
  end

  arb_state_t        r_state;
  logic [RUN_W-1:0]  r_vid_run;
  logic              w_tmo;
  logic              w_cpu_clr, w_vid_clr;
  logic              w_cpu_vld, w_vid_vld;
  logic [ADDR_W-1:0] w_cpu_addr, w_vid_addr;
  logic [DATA_W-1:0] w_cpu_wdata, w_vid_wdata;
  logic [1:0]        w_cpu_wstrb, w_vid_wstrb;
  logic              w_cpu_we, w_vid_we;
  logic              w_vid_starved;

  assign w_cpu_clr     = (r_state == ST_CPU) && (mem_ack || w_tmo);
  assign w_vid_clr     = (r_state == ST_VID) && (mem_ack || w_tmo);
  assign w_vid_starved = w_cpu_vld && (r_vid_run == RUN_W'(MAX_VID_RUN));

  blit_req_slot u_cpu_slot (
    .clk     (clk),
    .rst     (rst),
    .i_req   (cpu_ram_req),
    .i_addr  (cpu_ram_addr),
    .i_wdata (cpu_ram_wdata),
    .i_wstrb (cpu_ram_wstrb),
    .i_we    (cpu_ram_we),
    .i_clr   (w_cpu_clr),
    .o_vld   (w_cpu_vld),
    .o_addr  (w_cpu_addr),
    .o_wdata (w_cpu_wdata),
    .o_wstrb (w_cpu_wstrb),
    .o_we    (w_cpu_we)
  );

  // Video write fields are tied off so every video grant is a plain read.
  blit_req_slot u_vid_slot (
    .clk     (clk),
    .rst     (rst),
    .i_req   (vid_req),
    .i_addr  (vid_addr),
    .i_wdata ('0),
    .i_wstrb (2'b00),
    .i_we    (1'b0),
    .i_clr   (w_vid_clr),
    .o_vld   (w_vid_vld),
    .o_addr  (w_vid_addr),
    .o_wdata (w_vid_wdata),
    .o_wstrb (w_vid_wstrb),
    .o_we    (w_vid_we)
  );

`ifdef BLIT_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;
  assign w_tmo = (r_state != ST_IDLE) && !mem_ack && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_vid_run     <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 2'b00;
      mem_we        <= 1'b0;
      cpu_ram_ack   <= 1'b0;
      cpu_ram_rdata <= '0;
      vid_ack       <= 1'b0;
      vid_rdata     <= '0;
`ifdef BLIT_ARB_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      mem_req     <= 1'b0;
      cpu_ram_ack <= 1'b0;
      vid_ack     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_vid_vld && !w_vid_starved) begin
            r_state   <= ST_VID;
            mem_req   <= 1'b1;
            mem_addr  <= w_vid_addr;
            mem_wdata <= w_vid_wdata;
            mem_wstrb <= w_vid_wstrb;
            mem_we    <= w_vid_we;
            if (w_cpu_vld) r_vid_run <= r_vid_run + 1'b1;
          end else if (w_cpu_vld) begin
            r_state   <= ST_CPU;
            mem_req   <= 1'b1;
            mem_addr  <= w_cpu_addr;
            mem_wdata <= w_cpu_wdata;
            mem_wstrb <= w_cpu_wstrb;
            mem_we    <= w_cpu_we;
            r_vid_run <= '0;
          end
        end
        ST_CPU: begin
          if (mem_ack) begin
            cpu_ram_ack   <= 1'b1;
            cpu_ram_rdata <= mem_rdata;
            r_state       <= ST_IDLE;
          end else if (w_tmo) begin
            cpu_ram_ack   <= 1'b1;
            cpu_ram_rdata <= 16'hFFFF;
            r_state       <= ST_IDLE;
          end
        end
        ST_VID: begin
          if (mem_ack) begin
            vid_ack   <= 1'b1;
            vid_rdata <= mem_rdata;
            r_state   <= ST_IDLE;
          end else if (w_tmo) begin
            vid_ack   <= 1'b1;
            vid_rdata <= 16'hFFFF;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Starvation count only matters while the CPU is actually waiting.
      if (!w_cpu_vld) r_vid_run <= '0;
`ifdef BLIT_ARB_TIMEOUT_EN
      timeout_err <= w_tmo;
      if (r_state == ST_IDLE || mem_ack || w_tmo) r_tmo_cnt <= '0;
      else                                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_blit_ram_arb.sv
// Directed bench for blit_ram_arb (MAX_VID_RUN=4, TIMEOUT=8); covers both BLIT_ARB_TIMEOUT_EN builds.
module tb_blit_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ram_req;
  logic [17:0] cpu_ram_addr;
  logic [15:0] cpu_ram_wdata;
  logic [1:0]  cpu_ram_wstrb;
  logic        cpu_ram_we;
  logic        cpu_ram_ack;
  logic [15:0] cpu_ram_rdata;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wstrb;
  logic        mem_we;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  always #5 clk = ~clk;

  blit_ram_arb #(.MAX_VID_RUN(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_ram_req   (cpu_ram_req),
    .cpu_ram_addr  (cpu_ram_addr),
    .cpu_ram_wdata (cpu_ram_wdata),
    .cpu_ram_wstrb (cpu_ram_wstrb),
    .cpu_ram_we    (cpu_ram_we),
    .cpu_ram_ack   (cpu_ram_ack),
    .cpu_ram_rdata (cpu_ram_rdata),
    .vid_req       (vid_req),
    .vid_addr      (vid_addr),
    .vid_ack       (vid_ack),
    .vid_rdata     (vid_rdata),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_we        (mem_we),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .timeout_err   (timeout_err)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int n_mem_req = 0;
  int n_cpu_ack = 0;
  int n_tmo     = 0;
  int n_cpu_acc = 0;
  int base_req, base_ack, base_tmo;
  logic proto_err = 1'b0;

  always @(negedge clk) begin
    if (mem_req)     n_mem_req++;
    if (cpu_ram_ack) n_cpu_ack++;
    if (timeout_err) n_tmo++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cpu_ram_req = 1'b0;
    vid_req     = 1'b0;
    mem_ack     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A second pulse while the bench's own view of the CPU slot is still pending is a protocol error.
  task automatic cpu_pulse(input logic [17:0] a, input logic [15:0] d, input logic [1:0] s, input logic w);
    if (n_cpu_acc > n_cpu_ack + int'(cpu_ram_ack)) proto_err = 1'b1;
    else n_cpu_acc++;
    cpu_ram_req   = 1'b1;
    cpu_ram_addr  = a;
    cpu_ram_wdata = d;
    cpu_ram_wstrb = s;
    cpu_ram_we    = w;
  endtask

  task automatic vid_pulse(input logic [17:0] a);
    vid_req  = 1'b1;
    vid_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    cpu_ram_req = 1'b0; cpu_ram_addr = '0; cpu_ram_wdata = '0; cpu_ram_wstrb = '0; cpu_ram_we = 1'b0;
    vid_req = 1'b0; vid_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_outputs", 32'({cpu_ram_ack, vid_ack, mem_req, mem_we, timeout_err}), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_ram_rdata), 32'h0);
    chk("rst_vid_rdata", 32'(vid_rdata), 32'h0);

    // CPU read, mem_ack three cycles after mem_req
    cpu_pulse(18'h00100, 16'h0, 2'b00, 1'b0);
    step();
    chk("t1_mem_req", 32'(mem_req), 32'h1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h00100);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    step();
    chk("t1_req_one_cycle", 32'(mem_req), 32'h0);
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    chk("t1_cpu_ack", 32'(cpu_ram_ack), 32'h1);
    chk("t1_cpu_rdata", 32'(cpu_ram_rdata), 32'hBEEF);
    chk("t1_no_vid_ack", 32'(vid_ack), 32'h0);
    step();
    chk("t1_ack_one_cycle", 32'(cpu_ram_ack), 32'h0);

    // Simultaneous pulses: video first, then CPU write
    cpu_pulse(18'h00200, 16'hAAAA, 2'b11, 1'b1);
    vid_pulse(18'h00300);
    step();
    chk("t2_vid_grant", 32'({mem_req, mem_we, mem_wstrb}), 32'b1000);
    chk("t2_vid_addr", 32'(mem_addr), 32'h00300);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step();
    chk("t2_vid_ack", 32'({vid_ack, cpu_ram_ack, mem_req}), 32'b100);
    chk("t2_vid_rdata", 32'(vid_rdata), 32'h5555);
    step();
    chk("t2_cpu_grant", 32'({mem_req, mem_we, mem_wstrb}), 32'b1111);
    chk("t2_cpu_addr", 32'(mem_addr), 32'h00200);
    chk("t2_cpu_wdata", 32'(mem_wdata), 32'hAAAA);
    mem_ack = 1'b1; mem_rdata = 16'h0;
    step();
    chk("t2_cpu_ack", 32'(cpu_ram_ack), 32'h1);
    step();

    // Video re-pulsed on every ack while a CPU write waits: four video grants, then CPU
    cpu_pulse(18'h2ABCD, 16'h1234, 2'b01, 1'b1);
    vid_pulse(18'h00040);
    for (int g = 0; g < 4; g++) begin
      step();
      chk("t3_vid_grant", 32'({mem_req, mem_we, mem_wstrb}), 32'b1000);
      chk("t3_vid_addr", 32'(mem_addr), 32'h40 + 32'(g));
      mem_ack = 1'b1; mem_rdata = 16'(g);
      step();
      chk("t3_vid_ack", 32'(vid_ack), 32'h1);
      vid_pulse(18'(32'h41 + 32'(g)));
    end
    step();
    chk("t3_cpu_grant", 32'({mem_req, mem_we, mem_wstrb}), 32'b1101);
    chk("t3_cpu_wdata", 32'(mem_wdata), 32'h1234);
    chk("t3_cpu_addr", 32'(mem_addr), 32'h2ABCD);
    mem_ack = 1'b1; mem_rdata = 16'h0;
    step();
    chk("t3_cpu_ack", 32'(cpu_ram_ack), 32'h1);
    step();
    chk("t3_last_vid_grant", 32'({mem_req, mem_we}), 32'b10);
    chk("t3_last_vid_addr", 32'(mem_addr), 32'h00044);
    mem_ack = 1'b1;
    step();
    chk("t3_last_vid_ack", 32'(vid_ack), 32'h1);
    step();

    // Reset mid-access, then a late mem_ack
    base_ack = n_cpu_ack;
    cpu_pulse(18'h00500, 16'h0, 2'b00, 1'b0);
    step();
    chk("t4_mem_req", 32'(mem_req), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_outputs", 32'({mem_req, mem_we, cpu_ram_ack, vid_ack}), 32'h0);
    step();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    chk("t4_late_ack_ignored", 32'({cpu_ram_ack, vid_ack, mem_req}), 32'h0);
    step();
    chk("t4_no_cpu_ack", 32'(n_cpu_ack - base_ack), 32'h0);
    n_cpu_acc = n_cpu_ack;
    cpu_pulse(18'h00600, 16'h0, 2'b00, 1'b0);
    step();
    chk("t4_recover_req", 32'({mem_req, mem_we}), 32'b10);
    chk("t4_recover_addr", 32'(mem_addr), 32'h00600);
    mem_ack = 1'b1; mem_rdata = 16'h0600;
    step();
    chk("t4_recover_ack", 32'(cpu_ram_ack), 32'h1);
    chk("t4_recover_rdata", 32'(cpu_ram_rdata), 32'h0600);
    step();

    // Second CPU pulse while pending is dropped
    chk("t5_no_proto_yet", 32'(proto_err), 32'h0);
    base_req = n_mem_req;
    cpu_pulse(18'h00700, 16'h0, 2'b00, 1'b0);
    step();
    cpu_pulse(18'h00701, 16'h0, 2'b00, 1'b0);
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 16'h0007;
    step();
    chk("t5_cpu_ack", 32'(cpu_ram_ack), 32'h1);
    chk("t5_cpu_rdata", 32'(cpu_ram_rdata), 32'h0007);
    repeat (3) step();
    chk("t5_one_mem_req", 32'(n_mem_req - base_req), 32'h1);
    chk("t5_addr_first", 32'(mem_addr), 32'h00700);
    chk("t5_proto_flag", 32'(proto_err), 32'h1);

    // Unanswered access
    base_ack = n_cpu_ack;
    base_tmo = n_tmo;
    cpu_pulse(18'h00800, 16'h0, 2'b00, 1'b0);
    step();
    chk("t6_mem_req", 32'(mem_req), 32'h1);
`ifdef BLIT_ARB_TIMEOUT_EN
    repeat (7) step();
    chk("t6_no_early_ack", 32'({cpu_ram_ack, timeout_err}), 32'h0);
    step();
    chk("t6_tmo_ack", 32'({cpu_ram_ack, timeout_err, vid_ack}), 32'b110);
    chk("t6_tmo_rdata", 32'(cpu_ram_rdata), 32'hFFFF);
    step();
    chk("t6_tmo_pulse", 32'({cpu_ram_ack, timeout_err}), 32'h0);
    chk("t6_tmo_count", 32'(n_tmo - base_tmo), 32'h1);
`else
    repeat (1000) step();
    chk("t6_no_ack_1000", 32'(n_cpu_ack - base_ack), 32'h0);
    chk("t6_no_tmo_err", 32'(n_tmo - base_tmo), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/blit_ram_arb.md
BLIT_RAM_ARB -- requirements
Module: blit_ram_arb

Interface
REQ-001 SHALL have parameter MAX_VID_RUN, default 4: max consecutive video grants while a CPU request waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: cycles to wait for mem_ack before abort (only with BLIT_ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock and a synchronous active-high reset, declared first: clk  in  1  clock; rst  in  1  synchronous reset.
REQ-004 cpu_ram_req  in  1  one-cycle request pulse from the CPU bus decoder.
REQ-005 cpu_ram_addr  in  18  word-address bits; cpu_ram_wdata  in  16; cpu_ram_wstrb  in  2  byte strobes; cpu_ram_we  in  1  write enable.
REQ-006 cpu_ram_ack  out  1  one-cycle completion pulse; cpu_ram_rdata  out  16  read data, valid with ack.
REQ-007 vid_req  in  1  one-cycle read-request pulse from video fetch; vid_addr  in  18.
REQ-008 vid_ack  out  1  completion pulse; vid_rdata  out  16  read data.
REQ-009 mem_req  out  1  one-cycle request to the RAM controller; mem_addr  out  18; mem_wdata  out  16; mem_wstrb  out  2; mem_we  out  1.
REQ-010 mem_ack  in  1  RAM completion pulse; mem_rdata  in  16  read data, valid with mem_ack.
REQ-011 timeout_err  out  1  one-cycle pulse on an aborted access.

Function
REQ-012 Each source SHALL have one pending slot; a request pulse SHALL latch addr/wdata/wstrb/we into it in the same cycle.
REQ-013 A second pulse from a source whose slot is already pending SHALL be ignored; the bench SHALL flag it as a protocol error.
REQ-014 The state machine SHALL have states IDLE, CPU and VID.
REQ-015 IDLE: if only one slot is pending, grant it; if both are pending, grant VID unless vid_run == MAX_VID_RUN, in which case grant CPU.
REQ-016 On a grant, mem_req SHALL pulse for exactly one cycle and mem_* SHALL be driven from the granted slot; mem_* SHALL hold until the grant completes.
REQ-017 Latency: a pulse in cycle t on an idle arbiter SHALL give mem_req in cycle t+1.
REQ-018 In CPU or VID state, mem_ack SHALL:
  - pulse the matching ack in the next cycle, with rdata registered from mem_rdata;
  - clear that slot;
  - return the machine to IDLE.
REQ-019 A new grant SHALL NOT be issued in the same cycle as mem_ack; minimum spacing between mem_req pulses is 2 cycles.
REQ-020 vid_run SHALL increment on each VID grant made while the CPU slot is pending, saturate at MAX_VID_RUN, and clear on any CPU grant or whenever the CPU slot is empty.
REQ-021 Video grants SHALL force mem_we=0 and mem_wstrb=2'b00.
REQ-022 A request pulse arriving in the cycle its own ack is emitted SHALL be latched normally.
REQ-023 mem_ack received in IDLE SHALL be ignored.

Reset
REQ-024 rst SHALL clear both slots, vid_run and the timeout counter, and force IDLE.
REQ-025 rst SHALL force all ack/req/timeout_err outputs and mem_we to 0; rdata outputs SHALL reset to 16'h0000.
REQ-026 Reset mid-access SHALL drop the access without acking; a late mem_ack SHALL be ignored per REQ-023.

Configuration
REQ-027 With macro BLIT_ARB_TIMEOUT_EN defined:
  - a counter SHALL run in CPU/VID;
  - if TIMEOUT cycles pass without mem_ack, the granted source's ack SHALL pulse with rdata 16'hFFFF, timeout_err SHALL pulse in the same cycle, the slot SHALL clear, and the machine SHALL return to IDLE.
REQ-028 Without BLIT_ARB_TIMEOUT_EN, there SHALL be no counter, timeout_err SHALL be tied 0, and the arbiter SHALL wait indefinitely.

Structure
REQ-029 Shared package blit_pkg SHALL hold the state encodings (IDLE/CPU/VID), the RAM address width (18) and the default MAX_VID_RUN/TIMEOUT values.
REQ-030 Sub-module blit_req_slot SHALL implement one pending slot (pulse capture, hold, clear); it SHALL be instantiated twice.

Verification
REQ-031 CPU read, addr 18'h00100, mem_ack 3 cycles after mem_req with mem_rdata 16'hBEEF -> cpu_ram_ack one cycle after mem_ack, cpu_ram_rdata=16'hBEEF, no vid_ack.
REQ-032 Simultaneous cpu and vid pulses at cycle 0 -> VID granted first (mem_req cycle 1, mem_we=0), CPU granted after vid_ack.
REQ-033 vid_req re-pulsed on every vid_ack while CPU write (wdata 16'h1234, wstrb 2'b01) is pending, MAX_VID_RUN=4 -> exactly 4 VID grants, then CPU granted with mem_wstrb=2'b01.
REQ-034 rst asserted 1 cycle after mem_req, mem_ack arriving 2 cycles later -> no ack on either port, arbiter IDLE, next cpu pulse served normally.
REQ-035 With BLIT_ARB_TIMEOUT_EN, TIMEOUT=8, mem_ack never asserted -> cpu_ram_ack and timeout_err together 8 cycles after mem_req, rdata 16'hFFFF. Without the macro -> no ack for 1000 cycles.
REQ-036 Second cpu pulse while CPU slot pending -> ignored, exactly one mem_req for CPU, protocol-error flag raised.
